// File: rtl/img_pkg.sv
// Shared pixel/window types and kernel geometry for the image-processing datapath.
package img_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int KERNEL_SIZE = 3;

    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef pixel_t [0:KERNEL_SIZE*KERNEL_SIZE-1] window_t;

    // Row-major window positions: oldest sample, centre pixel, newest sample.
    localparam int WIN_TL = 0;
    localparam int WIN_C  = 4;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in / 3x3 window stream out, bundled for the window generator.
interface window_gen_3x3_if #(
    parameter int DATA_WIDTH = img_pkg::DATA_WIDTH
);

    logic                  pixel_valid;
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] pixel_in;
    logic [0:img_pkg::KERNEL_SIZE*img_pkg::KERNEL_SIZE-1][DATA_WIDTH-1:0] window_out;
    logic                  window_valid;
    logic                  frame_done;

    modport master (
        output pixel_valid, frame_start, pixel_in,
        input  window_out, window_valid, frame_done
    );

    modport slave (
        input  pixel_valid, frame_start, pixel_in,
        output window_out, window_valid, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image line of storage: single address, synchronous read-before-write.
module line_buffer #(
    parameter int DATA_WIDTH = img_pkg::DATA_WIDTH,
    parameter int DEPTH      = 640,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus per-row column taps,
// emitting a row-major window for every interior pixel with a fixed 2-cycle latency.
module window_gen_3x3
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = img_pkg::DATA_WIDTH,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    window_gen_3x3_if.slave  bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0]         col, col_eff, col_p1;
    logic [RW-1:0]         row, row_eff;
    logic                  vld_p1, emit_p1, last_p1;
    logic                  vld_p2, emit_p2, last_p2;
    logic [DATA_WIDTH-1:0] pix_p1, pix_p2;
    logic [DATA_WIDTH-1:0] rd_a_p1, rd_a_p2, rd_b_p2;
    logic [DATA_WIDTH-1:0] col_new [0:KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] tap     [0:KERNEL_SIZE-1][0:KERNEL_SIZE-2];

    // frame_start re-anchors the accepted pixel at (0,0) whatever the counters say.
    assign col_eff = bus.frame_start ? '0 : col;
    assign row_eff = bus.frame_start ? '0 : row;

    // ---- stage p0: position counters, line buffer A access ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.pixel_valid) begin
            if (col_eff == COL_LAST) begin
                col <= '0;
                row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col <= col_eff + 1'b1;
                row <= row_eff;
            end
        end
    end

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .AW         (CW)
    ) u_line_a (
        .clk   (clk),
        .en    (bus.pixel_valid),
        .addr  (col_eff),
        .wdata (bus.pixel_in),
        .rdata (rd_a_p1)
    );

    // ---- stage p1: row r-1 available; buffer B cascades A's old data one cycle later ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            emit_p1 <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= bus.pixel_valid;
            emit_p1 <= (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
            last_p1 <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        end
    end

    always_ff @(posedge clk) begin
        pix_p1 <= bus.pixel_in;
        col_p1 <= col_eff;
    end

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .AW         (CW)
    ) u_line_b (
        .clk   (clk),
        .en    (vld_p1),
        .addr  (col_p1),
        .wdata (rd_a_p1),
        .rdata (rd_b_p2)
    );

    // ---- stage p2: newest column of all three rows aligned ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            emit_p2 <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            emit_p2 <= emit_p1;
            last_p2 <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        rd_a_p2 <= rd_a_p1;
        pix_p2  <= pix_p1;
    end

    always_comb begin
        col_new[0] = rd_b_p2;
        col_new[1] = rd_a_p2;
        col_new[2] = pix_p2;
    end

    // Taps keep columns c-2..c-1 per row; they advance only on real pixels.
    always_ff @(posedge clk) begin
        if (vld_p2) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                for (int j = 0; j < KERNEL_SIZE - 2; j++) begin
                    tap[k][j] <= tap[k][j+1];
                end
                tap[k][KERNEL_SIZE-2] <= col_new[k];
            end
        end
    end

    // ---- output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.window_out   <= '0;
            bus.window_valid <= 1'b0;
            bus.frame_done   <= 1'b0;
        end else begin
            bus.window_valid <= vld_p2 && emit_p2;
            bus.frame_done   <= vld_p2 && last_p2;
            if (vld_p2 && emit_p2) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                        bus.window_out[k*KERNEL_SIZE + j] <= tap[k][j];
                    end
                    bus.window_out[k*KERNEL_SIZE + KERNEL_SIZE - 1] <= col_new[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 5x4 instance driven with raster frames and a 3x3 instance.
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct {
        logic [71:0] win;
        int          cyc;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    logic [71:0] last_exp = '0;

    logic [71:0] win3 = '0;
    int n3 = 0, fd3 = 0, win3_cyc = 0, fd3_cyc = 0;

    window_gen_3x3_if bus ();
    window_gen_3x3_if bus3 ();

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    window_gen_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return base + 8'((r << 4) | c);
    endfunction

    function automatic logic [71:0] exp_window(input logic [7:0] base, input int r, input int c);
        logic [71:0] w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], pix(base, r - 2 + dr, c - 2 + dc)};
        return w;
    endfunction

    // Scoreboard for the 5x4 instance: content, arrival cycle, frame_done, hold.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.window_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_win", 72'(1), 72'(0));
                end else begin
                    e = q.pop_front();
                    check("win", bus.window_out, e.win);
                    check("win_cyc", 72'(cyc), 72'(e.cyc));
                    check("frame_done", 72'(bus.frame_done), 72'(e.last));
                    last_exp = e.win;
                end
            end else begin
                check("hold", bus.window_out, last_exp);
                check("fd_idle", 72'(bus.frame_done), 72'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (bus3.window_valid) begin
            win3 = bus3.window_out;
            win3_cyc = cyc;
            n3++;
        end
        if (bus3.frame_done) begin
            fd3++;
            fd3_cyc = cyc;
        end
    end

    task automatic idle(input logic fs_noise);
        bus.pixel_valid = 1'b0;
        bus.frame_start = fs_noise;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] base, input logic fs, input int r, input int c);
        exp_t e;
        bus.pixel_in    = pix(base, r, c);
        bus.pixel_valid = 1'b1;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        if (r >= 2 && c >= 2) begin
            e.win  = exp_window(base, r, c);
            e.cyc  = cyc + 2;
            e.last = (r == H - 1) && (c == W - 1);
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input int max_gap, input bit fs_first,
                              input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (!(r == 0 && c == 0))
                    repeat ($urandom_range(0, max_gap)) idle(1'($urandom_range(0, 1)) & (max_gap > 0));
                send_pixel(base, fs_first && r == 0 && c == 0, r, c);
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (5) idle(1'b0);
        check(tag, 72'(q.size()), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc3;
        rst_n = 1'b0;
        bus.pixel_in = '0;  bus.pixel_valid = 1'b0;  bus.frame_start = 1'b0;
        bus3.pixel_in = '0; bus3.pixel_valid = 1'b0; bus3.frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_win", bus.window_out, 72'(0));
        check("rst_vld", 72'(bus.window_valid), 72'(0));
        check("rst_fd", 72'(bus.frame_done), 72'(0));
        check("rst3_vld", 72'(bus3.window_valid), 72'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Continuous frame with no frame_start: first pixel after reset is (0,0).
        send_frame(8'h00, 0, 1'b0, H, 0);
        drain("pending_cont");

        // Random idle gaps, frame_start noise while idle.
        send_frame(8'h00, 3, 1'b1, H, 0);
        drain("pending_gaps");

        // Back-to-back frames, second offset by 0x80.
        send_frame(8'h00, 0, 1'b1, H, 0);
        send_frame(8'h80, 0, 1'b1, H, 0);
        drain("pending_b2b");

        // Abort at (2,3): window (2,2) still emits, then a clean frame.
        send_frame(8'h00, 0, 1'b1, 2, 3);
        send_frame(8'h00, 0, 1'b1, H, 0);
        drain("pending_abort");

        // Asynchronous reset while window (2,2) is in flight.
        send_frame(8'h00, 0, 1'b1, 2, 3);
        #2;
        rst_n = 1'b0;
        q.delete();
        last_exp = '0;
        #1;
        check("async_win", bus.window_out, 72'(0));
        check("async_vld", 72'(bus.window_valid), 72'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        send_frame(8'h00, 1, 1'b0, H, 0);
        drain("pending_reset");

        // 3x3 image: exactly one window and one frame_done.
        n3 = 0;
        fd3 = 0;
        acc3 = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                bus3.pixel_in    = pix(8'h00, r, c);
                bus3.pixel_valid = 1'b1;
                bus3.frame_start = (r == 0 && c == 0);
                @(posedge clk);
                #1;
                acc3 = cyc;
            end
        end
        bus3.pixel_valid = 1'b0;
        bus3.frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("w3_count", 72'(n3), 72'(1));
        check("w3_fd_count", 72'(fd3), 72'(1));
        check("w3_win", win3, exp_window(8'h00, 2, 2));
        check("w3_cyc", 72'(win3_cyc), 72'(acc3 + 2));
        check("w3_fd_cyc", 72'(fd3_cyc), 72'(acc3 + 2));

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
